dac_spi_sched: RTL and testbench

Command scheduler for the AD5628 octal DAC. It owns the single SPI master (`spi_base`/`spi_control`) and, after reset, runs a fixed two-word initialisation sequence. It then shares the SPI link between `N_REQ` independent channel-update requesters using round-robin arbitration. It sits between application logic (waveform/level generators) and the SPI engine inside `TOP`.

---
 rtl/dac_spi_sched_pkg.sv | 36 +++
 rtl/dac_spi_sched_rr_arbiter.sv | 36 +++
 rtl/dac_spi_sched.sv | 138 +++++++++++++
 tb/tb_dac_spi_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_sched_pkg.sv
// Shared AD5628 command constants, word layout and scheduler state encoding.
// Combinational helpers only: no latency, no flow control.
package dac_defs;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
    localparam logic [3:0] CMD_RESET        = 4'h7;
    localparam logic [3:0] CMD_REF_SETUP    = 4'h8;

    localparam int CMD_LSB  = 24;
    localparam int ADDR_LSB = 20;
    localparam int DATA_LSB = 8;

    localparam logic [31:0] RST_WORD = {4'h0, CMD_RESET, 24'h00_0000};
    localparam logic [31:0] REF_WORD = {4'h0, CMD_REF_SETUP, 24'h00_0001};

    typedef enum logic [2:0] {
        INIT_RST = 3'd0,
        WAIT_RST = 3'd1,
        INIT_REF = 3'd2,
        WAIT_REF = 3'd3,
        IDLE     = 3'd4,
        XFER     = 3'd5
    } state_t;

    function automatic logic [31:0] pack_word(input logic [3:0]  cmd,
                                              input logic [3:0]  addr,
                                              input logic [11:0] data);
        logic [31:0] w;
        w = '0;
        w[CMD_LSB  +: 4]  = cmd;
        w[ADDR_LSB +: 4]  = addr;
        w[DATA_LSB +: 12] = data;
        return w;
    endfunction

endpackage

// File: rtl/dac_spi_sched_rr_arbiter.sv
// Round-robin pick of the first asserted request at or after ptr, wrapping.
// Purely combinational; grant is zero when no request is pending.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk from the farthest offset down so the nearest hit overwrites last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            idx = sum[IW-1:0];
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/dac_spi_sched.sv
// AD5628 SPI scheduler: two-word init, then round-robin channel updates with a watchdog.
// Grant 1 cycle after req; spi_req held until spi_done or timeout, ack 1 cycle after.
module dac_spi_sched
    import dac_defs::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    input  logic [N_REQ-1:0]      req,
    input  logic [3*N_REQ-1:0]    req_chan,
    input  logic [12*N_REQ-1:0]   req_code,
    output logic [N_REQ-1:0]      ack,
    output logic                  spi_req,
    output logic [31:0]           spi_word,
    input  logic                  spi_done,
    output logic                  init_done,
    output logic                  err_timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT);

    state_t             state_q, state_d;
    logic               spi_req_q, spi_req_d;
    logic [31:0]        spi_word_q, spi_word_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               init_done_q, init_done_d;
    logic               err_q, err_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      gnt_idx_q, gnt_idx_d;
    logic [WW-1:0]      wdog_q, wdog_d;

    logic [N_REQ-1:0]   arb_req;
    logic [N_REQ-1:0]   arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic [IW-1:0]      gnt_next;
    logic [2:0]         cap_chan;
    logic [11:0]        cap_code;
    logic               wd_expired;

    // A requester still showing its ack this cycle must not be re-granted.
    assign arb_req    = req & ~ack_q;
    assign cap_chan   = req_chan[3*arb_idx +: 3];
    assign cap_code   = req_code[12*arb_idx +: 12];
    assign gnt_next   = (gnt_idx_q == IW'(N_REQ - 1)) ? '0 : gnt_idx_q + IW'(1);
    assign wd_expired = (wdog_q == WW'(TIMEOUT - 1));

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (arb_req),
        .ptr     (rr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        spi_req_d   = spi_req_q;
        spi_word_d  = spi_word_q;
        ack_d       = '0;
        init_done_d = init_done_q;
        err_d       = 1'b0;
        rr_d        = rr_q;
        gnt_idx_d   = gnt_idx_q;
        wdog_d      = wdog_q;
        case (state_q)
            INIT_RST, INIT_REF: begin
                spi_req_d  = 1'b1;
                wdog_d     = '0;
                spi_word_d = (state_q == INIT_RST) ? RST_WORD : REF_WORD;
                state_d    = (state_q == INIT_RST) ? WAIT_RST : WAIT_REF;
            end
            WAIT_RST, WAIT_REF, XFER: begin
                // A done in the expiry cycle wins over the watchdog.
                if (spi_done || wd_expired) begin
                    spi_req_d = 1'b0;
                    err_d     = ~spi_done;
                    if (state_q == XFER) begin
                        ack_d[gnt_idx_q] = 1'b1;
                        rr_d             = gnt_next;
                        state_d          = IDLE;
                    end else if (!spi_done) begin
                        state_d = INIT_RST;
                    end else if (state_q == WAIT_RST) begin
                        state_d = INIT_REF;
                    end else begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            IDLE: begin
                if (|arb_gnt) begin
                    spi_req_d  = 1'b1;
                    wdog_d     = '0;
                    gnt_idx_d  = arb_idx;
                    spi_word_d = pack_word(CMD_WRITE_UPDATE, {1'b0, cap_chan}, cap_code);
                    state_d    = XFER;
                end
            end
            default: state_d = INIT_RST;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state_q     <= INIT_RST;
            spi_req_q   <= 1'b0;
            spi_word_q  <= '0;
            ack_q       <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            rr_q        <= '0;
            gnt_idx_q   <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            spi_req_q   <= spi_req_d;
            spi_word_q  <= spi_word_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            rr_q        <= rr_d;
            gnt_idx_q   <= gnt_idx_d;
            wdog_q      <= wdog_d;
        end
    end

    assign ack         = ack_q;
    assign spi_req     = spi_req_q;
    assign spi_word    = spi_word_q;
    assign init_done   = init_done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_dac_spi_sched.sv
// Scoreboarded bench for dac_spi_sched with a stub SPI engine and a round-robin reference model.
module tb_dac_spi_sched;

    localparam int N  = 4;
    localparam int TO = 64;
    localparam logic [31:0] W_RST = 32'h0700_0000;
    localparam logic [31:0] W_REF = 32'h0800_0001;

    logic              clk_sys = 1'b0;
    logic              rst_sys;
    logic [N-1:0]      req;
    logic [3*N-1:0]    req_chan;
    logic [12*N-1:0]   req_code;
    logic [N-1:0]      ack;
    logic              spi_req;
    logic [31:0]       spi_word;
    logic              spi_done;
    logic              init_done;
    logic              err_timeout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [31:0] exp_words[$];
    int          exp_acks[$];
    int rise_cnt = 0;
    int rise_cyc = 0;
    int done_cyc = -10;
    int err_cnt  = 0;
    int stub_dly = 0;
    logic        hang_en   = 1'b0;
    logic [31:0] hang_word = '0;
    int mptr = 0;
    logic [2:0]  rchan [N];
    logic [11:0] rcode [N];

    dac_spi_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_sys     (clk_sys),
        .rst_sys     (rst_sys),
        .req         (req),
        .req_chan    (req_chan),
        .req_code    (req_code),
        .ack         (ack),
        .spi_req     (spi_req),
        .spi_word    (spi_word),
        .spi_done    (spi_done),
        .init_done   (init_done),
        .err_timeout (err_timeout)
    );

    always #10 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [2:0] ch, input logic [11:0] cd);
        return {4'h0, 4'h3, 1'b0, ch, cd, 8'h00};
    endfunction

    task automatic raise(input int i, input logic [2:0] ch, input logic [11:0] cd);
        req_chan[3*i +: 3]   = ch;
        req_code[12*i +: 12] = cd;
        rchan[i] = ch;
        rcode[i] = cd;
        req[i]   = 1'b1;
    endtask

    // Reference model: a grant produces the packed word then an ack, and moves the pointer past it.
    task automatic expect_idx(input int i);
        exp_words.push_back(exp_word(rchan[i], rcode[i]));
        exp_acks.push_back(i);
        mptr = (i + 1) % N;
    endtask

    // Requesters drop their request on the cycle they see their ack.
    task automatic step();
        @(negedge clk_sys);
        for (int i = 0; i < N; i++) begin
            if (ack[i]) req[i] = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 3000 && !(exp_words.size() == 0 && exp_acks.size() == 0 && req == '0 && !spi_req)) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL %s: not idle after %0d cycles, %0d words and %0d acks outstanding",
                     name, n, exp_words.size(), exp_acks.size());
        end
    endtask

    task automatic wait_rise(input int r0, input string name);
        int n = 0;
        while (n < 500 && rise_cnt == r0) begin
            step();
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL %s: spi_req never rose, got %0d rises, expected more than %0d", name, rise_cnt, r0);
        end
    endtask

    task automatic wait_err(input string name);
        int n = 0;
        while (n < 500 && !err_timeout) begin
            step();
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL %s: err_timeout got 0 for %0d cycles, expected a pulse", name, n);
        end
    endtask

    // Stub SPI engine: answers each word after a delay unless told to hang on it.
    initial begin : stub
        int wcnt;
        wcnt = -1;
        spi_done = 1'b0;
        forever begin
            @(negedge clk_sys);
            spi_done = 1'b0;
            if (rst_sys !== 1'b1 || !spi_req) begin
                wcnt = -1;
            end else if (wcnt < 0) begin
                if (hang_en && spi_word == hang_word) wcnt = 1_000_000;
                else wcnt = (stub_dly > 0) ? stub_dly : int'($urandom_range(1, 8));
            end else if (wcnt == 0) begin
                spi_done = 1'b1;
                done_cyc = cyc;
                wcnt     = 1_000_000;
            end else begin
                wcnt--;
            end
        end
    end

    initial begin : monitor
        logic        prev_req;
        logic [31:0] held_word;
        prev_req  = 1'b0;
        held_word = '0;
        forever begin
            @(negedge clk_sys);
            if (rst_sys === 1'b1) begin
                if (spi_req && !prev_req) begin
                    rise_cnt++;
                    rise_cyc = cyc;
                    if (exp_words.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got 0x%08h, expected no transfer", spi_word);
                    end else begin
                        check("spi_word", spi_word, exp_words.pop_front());
                    end
                end
                if (spi_req && prev_req) check("word_stable", spi_word, held_word);
                if (ack != '0) begin
                    if (exp_acks.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_ack: got 0x%0h, expected none", ack);
                    end else begin
                        check("ack_onehot", 32'(ack), 32'(1) << exp_acks.pop_front());
                    end
                    check("ack_timing", 32'(err_timeout || (cyc == done_cyc + 1)), 32'd1);
                    check("ack_spi_req_low", 32'(spi_req), 32'd0);
                end
                if (err_timeout) err_cnt++;
            end
            prev_req  = spi_req;
            held_word = spi_word;
        end
    end

    initial begin : global_guard
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, %0d tests, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin : main
        int r0;
        req      = '0;
        req_chan = '0;
        req_code = '0;
        rst_sys  = 1'b1;
        #5 rst_sys = 1'b0;
        stub_dly = 40;
        repeat (3) step();
        check("rst_spi_req", 32'(spi_req), 32'd0);
        check("rst_spi_word", spi_word, 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        // Request pending during init must wait for init_done, then win first.
        exp_words.push_back(W_RST);
        exp_words.push_back(W_REF);
        rst_sys = 1'b1;
        raise(2, 3'd5, 12'h5A5);
        expect_idx(2);
        step();
        check("first_req_after_reset", 32'(spi_req), 32'd1);
        check("first_word_after_reset", spi_word, W_RST);
        check("init_done_during_init", 32'(init_done), 32'd0);
        wait_idle("init_and_early_req");
        check("init_done_after_init", 32'(init_done), 32'd1);

        // Single update: grant latency of one cycle.
        stub_dly = 5;
        raise(1, 3'd2, 12'hABC);
        expect_idx(1);
        step();
        check("grant_latency_req", 32'(spi_req), 32'd1);
        check("grant_latency_word", spi_word, 32'h032A_BC00);
        wait_idle("single_update");

        // Random bursts of simultaneous requests.
        stub_dly = 0;
        for (int p = 0; p < 25; p++) begin
            logic [N-1:0] m;
            int base;
            m = N'($urandom_range(1, (1 << N) - 1));
            base = mptr;
            for (int i = 0; i < N; i++) begin
                if (m[i]) raise(i, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)));
            end
            for (int k = 0; k < N; k++) begin
                if (m[(base + k) % N]) expect_idx((base + k) % N);
            end
            wait_idle("random_burst");
            repeat ($urandom_range(0, 3)) step();
        end

        // Dropped-before-grant request is never served; data changes after grant are ignored.
        stub_dly = 20;
        r0 = rise_cnt;
        raise(0, 3'd1, 12'h111);
        expect_idx(0);
        wait_rise(r0, "drop_test_rise");
        req_code[11:0] = 12'hBAD;
        raise(3, 3'd7, 12'hFFF);
        step();
        step();
        req[3] = 1'b0;
        wait_idle("drop_before_grant");
        repeat (5) step();
        check("dropped_req_no_grant", rise_cnt, r0 + 1);

        // Watchdog abort in XFER.
        stub_dly  = 0;
        raise(1, 3'd6, 12'h0F0);
        hang_word = exp_word(3'd6, 12'h0F0);
        hang_en   = 1'b1;
        expect_idx(1);
        r0 = rise_cnt;
        wait_rise(r0, "xfer_timeout_rise");
        wait_err("xfer_timeout");
        check("xfer_timeout_cycle", cyc - rise_cyc, TO);
        check("xfer_timeout_spi_req", 32'(spi_req), 32'd0);
        check("xfer_timeout_ack", 32'(ack), 32'h2);
        hang_en = 1'b0;
        wait_idle("after_xfer_timeout");

        // Reset asserted mid-transfer drops outputs immediately.
        stub_dly = 30;
        raise(2, 3'd1, 12'h321);
        exp_words.push_back(exp_word(3'd1, 12'h321));
        r0 = rise_cnt;
        wait_rise(r0, "mid_xfer_rise");
        repeat (5) step();
        #3 rst_sys = 1'b0;
        #1;
        check("async_rst_spi_req", 32'(spi_req), 32'd0);
        check("async_rst_init_done", 32'(init_done), 32'd0);
        check("async_rst_spi_word", spi_word, 32'd0);
        req  = '0;
        mptr = 0;
        step();
        step();
        exp_words.push_back(W_RST);
        exp_words.push_back(W_REF);
        rst_sys = 1'b1;
        step();
        check("rerun_first_word", spi_word, W_RST);
        wait_idle("rerun_init");
        check("rerun_init_done", 32'(init_done), 32'd1);

        // Pointer back at 0: order 0,2,3, then a reasserted 0 comes last.
        stub_dly = 3;
        raise(0, 3'd0, 12'h100);
        raise(2, 3'd2, 12'h200);
        raise(3, 3'd3, 12'h300);
        expect_idx(0);
        expect_idx(2);
        expect_idx(3);
        begin
            int n = 0;
            while (n < 200 && !ack[0]) begin
                step();
                n++;
            end
            check("ack0_seen", 32'(ack[0]), 32'd1);
        end
        raise(0, 3'd4, 12'h777);
        expect_idx(0);
        wait_idle("rr_order_with_reassert");

        // Watchdog abort in WAIT_REF restarts the init sequence.
        rst_sys = 1'b0;
        step();
        mptr      = 0;
        hang_word = W_REF;
        hang_en   = 1'b1;
        stub_dly  = 5;
        exp_words.push_back(W_RST);
        exp_words.push_back(W_REF);
        exp_words.push_back(W_RST);
        exp_words.push_back(W_REF);
        rst_sys = 1'b1;
        wait_err("wait_ref_timeout");
        check("wait_ref_timeout_cycle", cyc - rise_cyc, TO);
        check("wait_ref_timeout_init_done", 32'(init_done), 32'd0);
        check("wait_ref_timeout_spi_req", 32'(spi_req), 32'd0);
        check("wait_ref_timeout_ack", 32'(ack), 32'd0);
        hang_en = 1'b0;
        step();
        check("restart_spi_req", 32'(spi_req), 32'd1);
        check("restart_word", spi_word, W_RST);
        wait_idle("init_after_ref_timeout");
        check("init_done_after_restart", 32'(init_done), 32'd1);
        check("err_timeout_count", err_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
